// File: rtl/zorro_master_buffer_control.sv
// Zorro III master-cycle buffer and strobe control for NCR 53C710 DMA.
// Sequences the grant check, address phase, FCS_n, data phase and termination.
// It also steers the data buffers NCR->Zorro on writes and Zorro->NCR on reads.
// Every output is a flop loaded from the next-state decode, so each output changes
// on the same edge as the state it belongs to.
// After TERM the bus stays parked (BMASTER and address buffers on) for one IDLE
// cycle. This lets a back-to-back request keep bus ownership without a gap.
module zorro_master_buffer_control #(
    parameter int ADDR_SETUP = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic MASTER_REQ,
    input  logic NCR_READ,
    input  logic BGRANT,
    input  logic DTACK_n,
    input  logic BERR_n,
    output logic BMASTER,
    output logic FCS_n,
    output logic DOE,
    output logic ABOEL_n,
    output logic ABOEH_n,
    output logic DBOE_n,
    output logic D2Z_n,
    output logic Z2D_n,
    output logic DLATCH,
    output logic NCR_ACK,
    output logic NCR_BERR
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ADDR   = 3'd1;
    localparam logic [2:0] STROBE = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] LATCH  = 3'd4;
    localparam logic [2:0] TERM   = 3'd5;

    logic [2:0] state, state_next;
    logic [7:0] count, count_next;
    logic       dir_r, dir_next;
    logic       err_r, err_next;
    logic       dtack_s1, dtack_s2;
    logic       berr_s1, berr_s2;

    logic bus_on, strobe_on, data_on;
    logic bmaster_d, fcs_n_d, doe_d, aboe_n_d, dboe_n_d;
    logic d2z_n_d, z2d_n_d, dlatch_d, ack_d, berr_d;

    // Two-flop synchronizers for the asynchronous Zorro termination inputs
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            dtack_s1 <= 1'b1;
            dtack_s2 <= 1'b1;
            berr_s1  <= 1'b1;
            berr_s2  <= 1'b1;
        end else begin
            dtack_s1 <= DTACK_n;
            dtack_s2 <= dtack_s1;
            berr_s1  <= BERR_n;
            berr_s2  <= berr_s1;
        end
    end

    // Cycle sequencer: the shared counter is the address setup count in ADDR and the timeout in DATA
    always_comb begin
        state_next = state;
        count_next = count;
        dir_next   = dir_r;
        err_next   = err_r;
        case (state)
            IDLE: begin
                if (MASTER_REQ && BGRANT) begin
                    state_next = ADDR;
                    dir_next   = NCR_READ;
                    err_next   = 1'b0;
                    count_next = 8'(ADDR_SETUP);
                end
            end
            ADDR: begin
                if (!BGRANT) begin
                    state_next = IDLE;
                end else if (count <= 8'd1) begin
                    state_next = STROBE;
                    count_next = 8'd0;
                end else begin
                    count_next = count - 8'd1;
                end
            end
            STROBE: begin
                state_next = DATA;
                count_next = 8'(TIMEOUT);
            end
            DATA: begin
                if (!berr_s2) begin
                    state_next = TERM;
                    err_next   = 1'b1;
                end else if (!dtack_s2) begin
                    state_next = dir_r ? LATCH : TERM;
                    err_next   = 1'b0;
                end else if (count <= 8'd1) begin
                    state_next = TERM;
                    err_next   = 1'b1;
                    count_next = 8'd0;
                end else begin
                    count_next = count - 8'd1;
                end
            end
            LATCH: begin
                state_next = TERM;
                err_next   = 1'b0;
            end
            TERM: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counter and cycle attribute registers
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= IDLE;
            count <= 8'd0;
            dir_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            dir_r <= dir_next;
            err_r <= err_next;
        end
    end

    // Output decode from the state being entered, so the registered outputs line up with it
    always_comb begin
        bus_on    = (state_next != IDLE) || (state == TERM);
        strobe_on = (state_next == STROBE) || (state_next == DATA) || (state_next == LATCH);
        data_on   = (state_next == DATA) || (state_next == LATCH);
        bmaster_d = bus_on;
        aboe_n_d  = !bus_on;
        fcs_n_d   = !strobe_on;
        doe_d     = data_on;
        dboe_n_d  = !data_on;
        d2z_n_d   = !((state_next == DATA) && !dir_next);
        z2d_n_d   = !(data_on && dir_next);
        dlatch_d  = (state_next == LATCH);
        ack_d     = (state_next == TERM) && !err_next;
        berr_d    = (state_next == TERM) && err_next;
    end

    // Output registers
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            BMASTER  <= 1'b0;
            FCS_n    <= 1'b1;
            DOE      <= 1'b0;
            ABOEL_n  <= 1'b1;
            ABOEH_n  <= 1'b1;
            DBOE_n   <= 1'b1;
            D2Z_n    <= 1'b1;
            Z2D_n    <= 1'b1;
            DLATCH   <= 1'b0;
            NCR_ACK  <= 1'b0;
            NCR_BERR <= 1'b0;
        end else begin
            BMASTER  <= bmaster_d;
            FCS_n    <= fcs_n_d;
            DOE      <= doe_d;
            ABOEL_n  <= aboe_n_d;
            ABOEH_n  <= aboe_n_d;
            DBOE_n   <= dboe_n_d;
            D2Z_n    <= d2z_n_d;
            Z2D_n    <= z2d_n_d;
            DLATCH   <= dlatch_d;
            NCR_ACK  <= ack_d;
            NCR_BERR <= berr_d;
        end
    end

endmodule

// File: doc/zorro_master_buffer_control.md
Name: zorro_master_buffer_control

Overview:
- Controls the Zorro III address/data buffers and cycle strobes when the NCR 53C710 is bus master (DMA). It is the master-side counterpart of the slave-cycle buffer control.
- Sequences grant check, address phase, FCS_n, data phase and termination.
- Steers data direction opposite to slave cycles: NCR→Zorro on writes, Zorro→NCR on reads.
- Returns cycle acknowledge or bus error to the NCR-side interface logic.

Parameters:
- ADDR_SETUP, 1, CLK cycles address buffers are driven before FCS_n asserts (1..15).
- TIMEOUT, 255, CLK cycles in data phase without DTACK_n before forced bus error (1..255).

Ports:
- CLK  in  1  system clock
- RESET_n  in  1  asynchronous active-low reset
- MASTER_REQ  in  1  NCR requests a master cycle (level, held until NCR_ACK/NCR_BERR)
- NCR_READ  in  1  1 = NCR reads from Zorro, 0 = NCR writes; sampled at cycle start
- BGRANT  in  1  Zorro bus grant, already synchronized, active high
- DTACK_n  in  1  Zorro data acknowledge, asynchronous
- BERR_n  in  1  Zorro bus error, asynchronous
- BMASTER  out  1  board owns Zorro bus
- FCS_n  out  1  Zorro full cycle strobe
- DOE  out  1  Zorro data output enable
- ABOEL_n  out  1  low address buffer enable
- ABOEH_n  out  1  high address buffer enable
- DBOE_n  out  1  data buffer enable
- D2Z_n  out  1  data direction NCR→Zorro
- Z2D_n  out  1  data direction Zorro→NCR
- DLATCH  out  1  one-cycle pulse latching Zorro read data into NCR-side latch
- NCR_ACK  out  1  one-cycle pulse: cycle completed
- NCR_BERR  out  1  one-cycle pulse: cycle ended in error

Behaviour:
- Reset (async, RESET_n=0): state IDLE. All _n outputs 1. BMASTER, DOE, DLATCH, NCR_ACK, NCR_BERR 0. Counters and synchronizers cleared to the deasserted value.
- All outputs are registered. DTACK_n and BERR_n pass through 2-flop synchronizers, giving 2 cycles of latency to the FSM.
- IDLE:
  - All buffers off.
  - If MASTER_REQ=1 and BGRANT=1: go to ADDR, latch dir_r=NCR_READ, load counter=ADDR_SETUP.
- ADDR:
  - BMASTER=1; ABOEL_n=ABOEH_n=0.
  - Counter decrements each cycle. At 0, go to STROBE.
  - BGRANT=0 in ADDR aborts to IDLE: outputs return to reset values next cycle, with no ACK and no BERR.
- STROBE:
  - FCS_n=0; address buffers remain on. Lasts exactly 1 cycle.
  - Go to DATA and load timeout counter=TIMEOUT.
- DATA:
  - FCS_n=0, DOE=1, DBOE_n=0.
  - Direction by dir_r: read gives Z2D_n=0, D2Z_n=1; write gives D2Z_n=0, Z2D_n=1. D2Z_n and Z2D_n are never both 0.
  - Synced BERR_n=0 has priority: go to TERM with err=1.
  - Else synced DTACK_n=0: read goes to LATCH, write goes to TERM with err=0.
  - Else timeout counter reaches 0: go to TERM with err=1.
- LATCH:
  - DLATCH=1 for 1 cycle. Strobes and Z2D_n are held.
  - Go to TERM with err=0.
- TERM (1 cycle):
  - FCS_n=1, DOE=0, DBOE_n=1, D2Z_n=Z2D_n=1; address buffers still on.
  - NCR_ACK=~err, NCR_BERR=err.
  - Next state: ADDR (back-to-back) if MASTER_REQ=1 and BGRANT=1 on the cycle after TERM, else IDLE with BMASTER=0 and address buffers off.
  - MASTER_REQ is re-evaluated only after NCR_ACK/NCR_BERR has been seen, i.e. in IDLE.
- BGRANT loss after FCS_n asserts is ignored. The cycle completes and the block then returns to IDLE.
- MASTER_REQ deassertion mid-cycle is ignored until the cycle returns to IDLE.
- Total latency, write with zero-wait DTACK (ADDR_SETUP=1): request→FCS_n low is 2 cycles; DTACK_n low→NCR_ACK is 3 cycles (2 sync + TERM).
- Reset mid-cycle: all outputs go to reset values immediately (async), with no pulse outputs.

Test Plan:
- Reset with MASTER_REQ=1, BGRANT=1 held → all _n outputs 1, BMASTER=0. After release: ABOE*_n=0 within 1 cycle, FCS_n=0 2 cycles after.
- Write cycle, DTACK_n low 3 cycles after FCS_n → D2Z_n=0, Z2D_n=1, DBOE_n=0 during DATA; single NCR_ACK pulse; no DLATCH; FCS_n high in TERM.
- Read cycle, DTACK_n asserted → Z2D_n=0, D2Z_n=1; DLATCH pulses exactly 1 cycle before NCR_ACK; no cycle with D2Z_n=Z2D_n=0.
- No DTACK_n, TIMEOUT=8 → NCR_BERR pulse 8 cycles after entering DATA, NCR_ACK never asserted. Same result with BERR_n low while DTACK_n is also low (BERR priority).
- BGRANT dropped in ADDR with ADDR_SETUP=3 → return to IDLE, FCS_n never asserted, no pulses. BGRANT dropped after FCS_n → cycle completes with NCR_ACK.
- Two back-to-back requests with MASTER_REQ held → BMASTER stays 1 between cycles. FCS_n high for at least 1 cycle between cycles. Async reset asserted in DATA forces FCS_n=1 and DOE=0 without waiting for a clock edge.
